// File: rtl/data_mem_responder.sv
// Data-memory responder with programmable access latency.
//
// Accepts a single read or write request from the processor's data port,
// waits WAIT_CYCLES extra cycles, performs the access on a word-addressed
// backing store and returns a one-cycle ready pulse. Misaligned,
// out-of-range and read+write-together requests are flagged with err and
// leave the store untouched.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   mem_read   read request, held until ready
//   mem_write  write request, held until ready
//   addr       byte address
//   wdata      write data
//   rdata      read data (holds until next response or reset)
//   ready      one-cycle response pulse
//   err        error flag, meaningful while ready=1
//   busy       high whenever a transaction is in flight
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        rd_q, wr_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        accept;
  logic        access;
  logic        bad;
  logic [IdxW-1:0] idx;

  // Backing store; contents survive reset.
  logic [31:0] mem_q [DEPTH_WORDS];

  assign idx = addr_q[IdxW+1:2];

  // Error decode on the latched request: misaligned, beyond the store, or
  // both request types at once.
  assign bad = (addr_q[1:0] != 2'b00) ||
               (addr_q[31:IdxW+2] != '0) ||
               (rd_q && wr_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      StIdle: begin
        if (mem_read || mem_write) begin
          accept  = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          err_d   = bad;
          rdata_d = (!bad && rd_q) ? mem_q[idx] : 32'h0;
          state_d = StResp;
        end
      end
      StResp: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        rd_q    <= mem_read;
        wr_q    <= mem_write;
      end
    end
  end

  // Reset forces state to idle asynchronously, so an aborted write never
  // reaches this port.
  always_ff @(posedge clk) begin
    if (access && wr_q && !bad) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign rdata = rdata_q;
  assign ready = (state_q == StResp);
  assign err   = err_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder. Instance 0 uses WAIT_CYCLES=2,
// instance 1 uses WAIT_CYCLES=0; both have 256 words.
module tb_data_mem_responder;

  logic        clk;
  logic        rst       [2];
  logic        req_rd    [2];
  logic        req_wr    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [31:0] o_rdata   [2];
  logic        o_ready   [2];
  logic        o_err     [2];
  logic        o_busy    [2];

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .reset(rst[0]), .mem_read(req_rd[0]), .mem_write(req_wr[0]),
    .addr(req_addr[0]), .wdata(req_wdata[0]), .rdata(o_rdata[0]),
    .ready(o_ready[0]), .err(o_err[0]), .busy(o_busy[0])
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset(rst[1]), .mem_read(req_rd[1]), .mem_write(req_wr[1]),
    .addr(req_addr[1]), .wdata(req_wdata[1]), .rdata(o_rdata[1]),
    .ready(o_ready[1]), .err(o_err[1]), .busy(o_busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model + compare process ----------------
  bit          m_pend  [2];
  int          m_t0    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wd    [2];
  bit          m_r     [2];
  bit          m_w     [2];
  logic [31:0] m_rdata [2];
  bit          m_err   [2];
  bit          m_known [2];
  logic [31:0] m_mem   [int];

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic model_edge(input int d);
    bit bad;
    int key;
    if (rst[d]) begin
      m_pend[d] = 0; m_rdata[d] = 32'h0; m_known[d] = 1;
    end else if (!m_pend[d]) begin
      if (req_rd[d] || req_wr[d]) begin
        m_pend[d] = 1; m_t0[d] = cyc;
        m_addr[d] = req_addr[d]; m_wd[d] = req_wdata[d];
        m_r[d] = req_rd[d]; m_w[d] = req_wr[d];
      end
    end else begin
      if (cyc == m_t0[d] + wait_of(d) + 1) begin
        bad = (m_addr[d] % 4 != 0) || (m_addr[d] >= 32'd1024) || (m_r[d] && m_w[d]);
        key = d * 256 + int'(m_addr[d] / 4);
        m_err[d] = bad;
        if (bad) begin
          m_rdata[d] = 32'h0; m_known[d] = 1;
        end else if (m_w[d]) begin
          m_mem[key] = m_wd[d]; m_rdata[d] = 32'h0; m_known[d] = 1;
        end else if (m_mem.exists(key)) begin
          m_rdata[d] = m_mem[key]; m_known[d] = 1;
        end else begin
          m_known[d] = 0;
        end
      end
      if (cyc == m_t0[d] + wait_of(d) + 2) m_pend[d] = 0;
    end
  endtask

  task automatic model_check(input int d);
    bit exp_rdy, exp_busy;
    if (rst[d]) begin
      m_pend[d] = 0; m_rdata[d] = 32'h0; m_known[d] = 1;
    end
    exp_rdy  = m_pend[d] && (cyc == m_t0[d] + wait_of(d) + 1);
    exp_busy = m_pend[d] && (cyc <= m_t0[d] + wait_of(d) + 1);
    nvec++;
    if (o_ready[d] !== exp_rdy) begin
      nerr++;
      $display("FAIL ready[%0d] cyc %0d: got %b want %b", d, cyc, o_ready[d], exp_rdy);
    end
    nvec++;
    if (o_busy[d] !== exp_busy) begin
      nerr++;
      $display("FAIL busy[%0d] cyc %0d: got %b want %b", d, cyc, o_busy[d], exp_busy);
    end
    if (m_known[d]) begin
      nvec++;
      if (o_rdata[d] !== m_rdata[d]) begin
        nerr++;
        $display("FAIL rdata[%0d] cyc %0d: got %h want %h", d, cyc, o_rdata[d], m_rdata[d]);
      end
    end
    if (exp_rdy) begin
      nvec++;
      if (o_err[d] !== m_err[d]) begin
        nerr++;
        $display("FAIL err[%0d] cyc %0d: got %b want %b", d, cyc, o_err[d], m_err[d]);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = 0; m_t0[d] = 0; m_rdata[d] = 32'h0; m_known[d] = 1; m_err[d] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) model_edge(d);
      @(negedge clk);
      for (int d = 0; d < 2; d++) model_check(d);
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One full transaction; lat counts negedges from the acceptance cycle to ready.
  task automatic txn(input int d, input bit r, input bit w, input logic [31:0] a,
                     input logic [31:0] dat, input bit tog,
                     output logic [31:0] got_rdata, output logic got_err, output int lat);
    @(posedge clk); #2;
    req_rd[d] = r; req_wr[d] = w; req_addr[d] = a; req_wdata[d] = dat;
    @(posedge clk);
    if (tog) begin
      #2;
      req_rd[d] = ~r; req_addr[d] = 32'h10; req_wdata[d] = 32'hFFFF_FFFF;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_ready[d] && lat < 40);
    lit("ready_seen", 32'(o_ready[d]), 32'd1);
    got_rdata = o_rdata[d];
    got_err   = o_err[d];
    @(posedge clk); #2;
    req_rd[d] = 1'b0; req_wr[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] rv;
    logic        ev;
    int          lat, n, p1;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; req_rd[d] = 1'b0; req_wr[d] = 1'b0;
      req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
    end
    #1;
    rst[0] = 1'b1; rst[1] = 1'b1;
    #1;
    lit("reset_rdata", o_rdata[0], 32'h0);
    lit("reset_ready", 32'(o_ready[0]), 32'd0);
    lit("reset_busy", 32'(o_busy[0]), 32'd0);
    lit("reset_err", 32'(o_err[1]), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Latency and read-after-write, WAIT_CYCLES=2.
    txn(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 0, rv, ev, lat);
    lit("w2_write_latency", 32'(lat), 32'd4);
    lit("w2_write_err", 32'(ev), 32'd0);
    txn(0, 1, 0, 32'h10, 32'h0, 0, rv, ev, lat);
    lit("w2_read_rdata", rv, 32'hDEAD_BEEF);
    @(negedge clk);
    lit("w2_ready_one_cycle", 32'(o_ready[0]), 32'd0);

    // Back-to-back held reads, WAIT_CYCLES=0.
    txn(1, 0, 1, 32'h0, 32'h1111_1111, 0, rv, ev, lat);
    lit("w0_latency", 32'(lat), 32'd2);
    txn(1, 0, 1, 32'h4, 32'h2222_2222, 0, rv, ev, lat);
    @(posedge clk); #2;
    req_rd[1] = 1'b1; req_addr[1] = 32'h0;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_ready[1] && n < 20);
    lit("b2b_first_ready", 32'(o_ready[1]), 32'd1);
    lit("b2b_first_rdata", o_rdata[1], 32'h1111_1111);
    p1 = cyc;
    @(posedge clk); #2;
    req_addr[1] = 32'h4;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_ready[1] && n < 20);
    lit("b2b_second_ready", 32'(o_ready[1]), 32'd1);
    lit("b2b_second_rdata", o_rdata[1], 32'h2222_2222);
    lit("b2b_spacing", 32'(cyc - p1), 32'd3);
    @(posedge clk); #2;
    req_rd[1] = 1'b0;

    // Misaligned write leaves the store alone.
    txn(0, 0, 1, 32'h13, 32'h5555_5555, 0, rv, ev, lat);
    lit("misalign_err", 32'(ev), 32'd1);
    lit("misalign_rdata", rv, 32'h0);
    txn(0, 1, 0, 32'h10, 32'h0, 0, rv, ev, lat);
    lit("misalign_old_value", rv, 32'hDEAD_BEEF);

    // Range boundary.
    txn(0, 0, 1, 32'h3FC, 32'h0BAD_F00D, 0, rv, ev, lat);
    txn(0, 1, 0, 32'h400, 32'h0, 0, rv, ev, lat);
    lit("oor_err", 32'(ev), 32'd1);
    lit("oor_rdata", rv, 32'h0);
    txn(0, 1, 0, 32'h3FC, 32'h0, 0, rv, ev, lat);
    lit("last_word_err", 32'(ev), 32'd0);
    lit("last_word_rdata", rv, 32'h0BAD_F00D);

    // Reset during WAIT aborts the pending write.
    txn(0, 0, 1, 32'h20, 32'h1234_5678, 0, rv, ev, lat);
    @(posedge clk); #2;
    req_wr[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'hCAFE_F00D;
    @(posedge clk); #2;
    rst[0] = 1'b1;
    #1;
    lit("abort_busy", 32'(o_busy[0]), 32'd0);
    lit("abort_ready", 32'(o_ready[0]), 32'd0);
    req_wr[0] = 1'b0;
    @(posedge clk); #2;
    rst[0] = 1'b0;
    txn(0, 1, 0, 32'h20, 32'h0, 0, rv, ev, lat);
    lit("abort_old_value", rv, 32'h1234_5678);

    // Read+write together, with inputs disturbed during WAIT.
    txn(0, 0, 1, 32'h8, 32'hA5A5_A5A5, 0, rv, ev, lat);
    txn(0, 1, 1, 32'h8, 32'h7777_7777, 1, rv, ev, lat);
    lit("both_err", 32'(ev), 32'd1);
    lit("both_rdata", rv, 32'h0);
    txn(0, 1, 0, 32'h8, 32'h0, 0, rv, ev, lat);
    lit("both_store_kept", rv, 32'hA5A5_A5A5);
    txn(0, 1, 0, 32'h10, 32'h0, 0, rv, ev, lat);
    lit("toggle_store_kept", rv, 32'hDEAD_BEEF);

    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
